// File: rtl/pong_pkg.sv
// Shared constants for the pong design: state encodings, BCD helpers, event bit indices.
// PONG_PAUSE_EN adds the PAUSE state encoding.
package pong_pkg;

   localparam int BCD_W    = 4;
   localparam int EVT_HIT  = 0;
   localparam int EVT_MISS = 1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SERVE     = 3'd1,
      ST_PLAY      = 3'd2,
      ST_MISS      = 3'd3,
`ifdef PONG_PAUSE_EN
      ST_GAME_OVER = 3'd4,
      ST_PAUSE     = 3'd5
`else
      ST_GAME_OVER = 3'd4
`endif
   } state_t;

   // Two-digit packed BCD increment that saturates at 99.
   function automatic logic [2*BCD_W-1:0] bcd_inc(input logic [2*BCD_W-1:0] s);
      logic [BCD_W-1:0] lo;
      logic [BCD_W-1:0] hi;
      lo = s[BCD_W-1:0];
      hi = s[2*BCD_W-1:BCD_W];
      if (s == 8'h99) return s;
      if (lo == 4'd9) begin
         lo = '0;
         hi = hi + 4'd1;
      end else begin
         lo = lo + 4'd1;
      end
      return {hi, lo};
   endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Game-controller bus: frame/button/event inputs and state/score outputs to datapath and OSD.
interface pong_game_ctrl_if;
   logic       end_of_frame;
   logic       button_left;
   logic       button_right;
   logic       hit_evt;
   logic       miss_evt;
   logic [2:0] game_state;
   logic       ball_run;
   logic       paddle_run;
   logic       ball_reset;
   logic [7:0] score;
   logic [2:0] lives;
   logic [3:0] level;

   modport master (
      input  end_of_frame, button_left, button_right, hit_evt, miss_evt,
      output game_state, ball_run, paddle_run, ball_reset, score, lives, level
   );

   modport slave (
      output end_of_frame, button_left, button_right, hit_evt, miss_evt,
      input  game_state, ball_run, paddle_run, ball_reset, score, lives, level
   );
endinterface

// File: rtl/frame_timer.sv
// Loadable 8-bit frame down-counter; done is high while the count sits at zero.
module frame_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       dec,
   output logic       done
);

   logic [7:0] count;

   // Load beats decrement so a frame tick on the entry cycle is not counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   count <= '0;
      else if (load)                count <= load_val;
      else if (dec && count != '0)  count <= count - 8'd1;
   end

   assign done = (count == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow sequencer: state, lives, BCD score and speed level, stepped by end_of_frame.
// Define PONG_PAUSE_EN to add the two-button PAUSE toggle in PLAY.
module pong_game_ctrl #(
   parameter int LIVES          = 3,
   parameter int SERVE_FRAMES   = 90,
   parameter int MISS_FRAMES    = 60,
   parameter int HITS_PER_LEVEL = 5,
   parameter int MAX_LEVEL      = 9
) (
   input  logic             clk,
   input  logic             reset_n,
   pong_game_ctrl_if.master bus
);
   import pong_pkg::*;

   localparam logic [2:0] LIVES_V = 3'(LIVES);
   localparam logic [7:0] SERVE_V = 8'(SERVE_FRAMES);
   localparam logic [7:0] MISS_V  = 8'(MISS_FRAMES);
   localparam logic [3:0] HPL_V   = 4'(HITS_PER_LEVEL);
   localparam logic [3:0] MAXL_V  = 4'(MAX_LEVEL);

   logic [1:0] rst_sync;
   logic       rst_n;
   state_t     state, state_nxt;
   logic       btn_l_q, btn_r_q;
   logic       rise_l, rise_r, start_press;
   logic [1:0] evt;
   logic       tmr_load, tmr_done;
   logic [7:0] tmr_val;
   logic       new_game, do_hit, do_miss, serve_pulse;
   logic [7:0] score;
   logic [2:0] lives;
   logic [3:0] level;
   logic [3:0] hit_cnt;
   logic       ball_reset;

   // Asynchronous assert, clk-synchronous release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync <= 2'b00;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   assign rise_l      = bus.button_left  & ~btn_l_q;
   assign rise_r      = bus.button_right & ~btn_r_q;
   assign start_press = rise_l | rise_r;
   assign evt[EVT_HIT]  = bus.hit_evt;
   assign evt[EVT_MISS] = bus.miss_evt;

`ifdef PONG_PAUSE_EN
   logic pause_combo;
   // Any rising edge while both buttons are down: simultaneous press or hold-plus-press.
   assign pause_combo = start_press & bus.button_left & bus.button_right;
`endif

   frame_timer u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (bus.end_of_frame),
      .done     (tmr_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      tmr_load    = 1'b0;
      tmr_val     = SERVE_V;
      new_game    = 1'b0;
      do_hit      = 1'b0;
      do_miss     = 1'b0;
      serve_pulse = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_press) begin
               state_nxt   = ST_SERVE;
               tmr_load    = 1'b1;
               new_game    = 1'b1;
               serve_pulse = 1'b1;
            end
         end
         ST_SERVE: begin
            if (tmr_done) state_nxt = ST_PLAY;
         end
         ST_PLAY: begin
`ifdef PONG_PAUSE_EN
            if (pause_combo) state_nxt = ST_PAUSE;
            else
`endif
            if (evt[EVT_MISS]) begin
               state_nxt = ST_MISS;
               tmr_load  = 1'b1;
               tmr_val   = MISS_V;
               do_miss   = 1'b1;
            end else if (evt[EVT_HIT]) begin
               do_hit = 1'b1;
            end
         end
         ST_MISS: begin
            if (tmr_done) begin
               if (lives == '0) begin
                  state_nxt = ST_GAME_OVER;
               end else begin
                  state_nxt   = ST_SERVE;
                  tmr_load    = 1'b1;
                  serve_pulse = 1'b1;
               end
            end
         end
         ST_GAME_OVER: begin
            if (start_press) state_nxt = ST_IDLE;
         end
`ifdef PONG_PAUSE_EN
         ST_PAUSE: begin
            if (pause_combo) state_nxt = ST_PLAY;
         end
`endif
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_l_q    <= 1'b0;
         btn_r_q    <= 1'b0;
         ball_reset <= 1'b0;
         score      <= '0;
         lives      <= LIVES_V;
         level      <= '0;
         hit_cnt    <= '0;
      end else begin
         btn_l_q    <= bus.button_left;
         btn_r_q    <= bus.button_right;
         ball_reset <= serve_pulse;
         if (new_game) begin
            score   <= '0;
            lives   <= LIVES_V;
            level   <= '0;
            hit_cnt <= '0;
         end else if (do_miss) begin
            lives   <= lives - 3'd1;
            hit_cnt <= '0;
         end else if (do_hit) begin
            score <= bcd_inc(score);
            if (hit_cnt + 4'd1 == HPL_V) begin
               hit_cnt <= '0;
               if (level != MAXL_V) level <= level + 4'd1;
            end else begin
               hit_cnt <= hit_cnt + 4'd1;
            end
         end
      end
   end

   assign bus.game_state = state;
   assign bus.ball_run   = (state == ST_PLAY);
   assign bus.paddle_run = (state == ST_PLAY) || (state == ST_SERVE);
   assign bus.ball_reset = ball_reset;
   assign bus.score      = score;
   assign bus.lives      = lives;
   assign bus.level      = level;

endmodule
